nx_rbus_decode_timeout: RTL and testbench

RBUS target-side decoder that sits directly downstream of the APB-to-RBUS bridge. It consumes the bridge's single-cycle rd/wr strobes and fans each request out to one of N_TGT register targets, selected by an address field. It returns exactly one ack or err_ack per accepted request. A watchdog converts any target that never responds into an err_ack, so the upstream APB transfer always completes.

---
 rtl/nx_rbus_decode_timeout.sv | 177 +++++++++++++++++
 tb/tb_nx_rbus_decode_timeout.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nx_rbus_decode_timeout.sv
// rtl/nx_rbus_decode_timeout.sv - RBUS target decoder with a response watchdog
// Optional status outputs (timeout count, last error address) under NX_RBUS_DECODE_STATUS_EN.
module nx_rbus_decode_timeout #(
  parameter int N_RBUS_ADDR_BITS = 32,
  parameter int N_RBUS_DATA_BITS = 32,
  parameter int N_TGT_SEL_BITS   = 2,
  parameter int TGT_SEL_LSB      = 12,
  parameter logic [(1 << N_TGT_SEL_BITS)-1:0] TGT_EN_MASK = '1,
  parameter int TIMEOUT_CYCLES   = 16,
  parameter logic [N_RBUS_DATA_BITS-1:0] TIMEOUT_DATA = 32'hDEAD_0000
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic [N_RBUS_ADDR_BITS-1:0]                       rbus_addr_i,
  input  logic [N_RBUS_DATA_BITS-1:0]                       rbus_wr_data_i,
  input  logic                                              rbus_wr_strb_i,
  input  logic                                              rbus_rd_strb_i,
  output logic [N_RBUS_DATA_BITS-1:0]                       rbus_rd_data_o,
  output logic                                              rbus_ack_o,
  output logic                                              rbus_err_ack_o,
  output logic                                              rbus_drop_o,
  output logic [N_RBUS_ADDR_BITS-1:0]                       tgt_addr_o,
  output logic [N_RBUS_DATA_BITS-1:0]                       tgt_wr_data_o,
  output logic [(1 << N_TGT_SEL_BITS)-1:0]                  tgt_wr_strb_o,
  output logic [(1 << N_TGT_SEL_BITS)-1:0]                  tgt_rd_strb_o,
  input  logic [(1 << N_TGT_SEL_BITS)*N_RBUS_DATA_BITS-1:0] tgt_rd_data_i,
  input  logic [(1 << N_TGT_SEL_BITS)-1:0]                  tgt_ack_i,
  input  logic [(1 << N_TGT_SEL_BITS)-1:0]                  tgt_err_ack_i
`ifdef NX_RBUS_DECODE_STATUS_EN
  ,
  output logic [15:0]                                       timeout_cnt_o,
  output logic [N_RBUS_ADDR_BITS-1:0]                       last_err_addr_o
`endif
);

  localparam int N_TGT = 1 << N_TGT_SEL_BITS;
  localparam int DW = N_RBUS_DATA_BITS;
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t                    state_q, state_d;
  logic [15:0]               cnt_q, cnt_d;
  logic [N_TGT_SEL_BITS-1:0] sel_q, sel_d, sel_in;
  logic                      is_rd_q, is_rd_d;
  logic [N_RBUS_ADDR_BITS-1:0] addr_q, addr_d;
  logic [DW-1:0]             wdata_q, wdata_d, rdata_q, rdata_d, sel_rdata;
  logic                      ack_q, ack_d, err_q, err_d, drop_q, drop_d;
  logic [N_TGT-1:0]          twr_q, twr_d, trd_q, trd_d;
  logic                      req, sel_ack, sel_err;

  assign req       = rbus_wr_strb_i | rbus_rd_strb_i;
  assign sel_in    = rbus_addr_i[TGT_SEL_LSB +: N_TGT_SEL_BITS];
  assign sel_ack   = tgt_ack_i[sel_q];
  assign sel_err   = tgt_err_ack_i[sel_q];
  assign sel_rdata = tgt_rd_data_i[sel_q*DW +: DW];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    is_rd_d = is_rd_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    drop_d  = 1'b0;
    twr_d   = '0;
    trd_d   = '0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          addr_d  = rbus_addr_i;
          wdata_d = rbus_wr_data_i;
          is_rd_d = rbus_rd_strb_i;
          sel_d   = sel_in;
          // Ambiguous or unpopulated requests complete locally without touching any target
          if ((rbus_wr_strb_i && rbus_rd_strb_i) || !TGT_EN_MASK[sel_in]) begin
            state_d = DONE;
            err_d   = 1'b1;
            rdata_d = TIMEOUT_DATA;
          end else begin
            state_d       = WAIT;
            cnt_d         = '0;
            twr_d[sel_in] = rbus_wr_strb_i;
            trd_d[sel_in] = rbus_rd_strb_i;
          end
        end
      end
      WAIT: begin
        drop_d = req;
        if (sel_err) begin
          state_d = DONE;
          err_d   = 1'b1;
          rdata_d = sel_rdata;
        end else if (sel_ack) begin
          state_d = DONE;
          ack_d   = 1'b1;
          rdata_d = is_rd_q ? sel_rdata : '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          err_d   = 1'b1;
          rdata_d = TIMEOUT_DATA;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DONE: begin
        drop_d  = req;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      is_rd_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      drop_q  <= 1'b0;
      twr_q   <= '0;
      trd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      is_rd_q <= is_rd_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      drop_q  <= drop_d;
      twr_q   <= twr_d;
      trd_q   <= trd_d;
    end
  end

  assign rbus_rd_data_o = rdata_q;
  assign rbus_ack_o     = ack_q;
  assign rbus_err_ack_o = err_q;
  assign rbus_drop_o    = drop_q;
  assign tgt_addr_o     = addr_q;
  assign tgt_wr_data_o  = wdata_q;
  assign tgt_wr_strb_o  = twr_q;
  assign tgt_rd_strb_o  = trd_q;

`ifdef NX_RBUS_DECODE_STATUS_EN
  logic [15:0]                 tmo_cnt_q;
  logic [N_RBUS_ADDR_BITS-1:0] last_err_q;
  logic                        tmo_hit;

  assign tmo_hit = (state_q == WAIT) && !sel_err && !sel_ack && (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q  <= '0;
      last_err_q <= '0;
    end else begin
      if (tmo_hit && (tmo_cnt_q != 16'hFFFF)) tmo_cnt_q <= tmo_cnt_q + 16'd1;
      if (err_d) last_err_q <= addr_d;
    end
  end

  assign timeout_cnt_o   = tmo_cnt_q;
  assign last_err_addr_o = last_err_q;
`endif

endmodule

// File: tb/tb_nx_rbus_decode_timeout.sv
// tb/tb_nx_rbus_decode_timeout.sv - randomized transaction-model bench for nx_rbus_decode_timeout
// Checks status outputs too when NX_RBUS_DECODE_STATUS_EN is defined.
module tb_nx_rbus_decode_timeout;
  localparam int T = 16;
  localparam logic [3:0] MASK = 4'b0111;
  localparam logic [31:0] TDATA = 32'hDEAD_0000;
  localparam int MAXC = 8192;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  rbus_addr_i = '0, rbus_wr_data_i = '0;
  logic         rbus_wr_strb_i = 1'b0, rbus_rd_strb_i = 1'b0;
  logic [31:0]  rbus_rd_data_o;
  logic         rbus_ack_o, rbus_err_ack_o, rbus_drop_o;
  logic [31:0]  tgt_addr_o, tgt_wr_data_o;
  logic [3:0]   tgt_wr_strb_o, tgt_rd_strb_o;
  logic [127:0] tgt_rd_data_i = '0;
  logic [3:0]   tgt_ack_i = '0, tgt_err_ack_i = '0;
`ifdef NX_RBUS_DECODE_STATUS_EN
  logic [15:0]  timeout_cnt_o;
  logic [31:0]  last_err_addr_o;
`endif

  nx_rbus_decode_timeout #(.TGT_EN_MASK(MASK), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst),
    .rbus_addr_i(rbus_addr_i), .rbus_wr_data_i(rbus_wr_data_i),
    .rbus_wr_strb_i(rbus_wr_strb_i), .rbus_rd_strb_i(rbus_rd_strb_i),
    .rbus_rd_data_o(rbus_rd_data_o), .rbus_ack_o(rbus_ack_o),
    .rbus_err_ack_o(rbus_err_ack_o), .rbus_drop_o(rbus_drop_o),
    .tgt_addr_o(tgt_addr_o), .tgt_wr_data_o(tgt_wr_data_o),
    .tgt_wr_strb_o(tgt_wr_strb_o), .tgt_rd_strb_o(tgt_rd_strb_o),
    .tgt_rd_data_i(tgt_rd_data_i), .tgt_ack_i(tgt_ack_i), .tgt_err_ack_i(tgt_err_ack_i)
`ifdef NX_RBUS_DECODE_STATUS_EN
    , .timeout_cnt_o(timeout_cnt_o), .last_err_addr_o(last_err_addr_o)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected outputs indexed by absolute cycle number
  logic        exp_ack [MAXC];
  logic        exp_err [MAXC];
  logic        exp_drop[MAXC];
  logic        exp_zero[MAXC];
  logic [31:0] exp_data[MAXC];
  logic [3:0]  exp_twr [MAXC];
  logic [3:0]  exp_trd [MAXC];
  logic [31:0] exp_taddr[MAXC];
  logic [31:0] exp_twd [MAXC];
`ifdef NX_RBUS_DECODE_STATUS_EN
  logic        exp_tmo  [MAXC];
  logic [31:0] exp_eaddr[MAXC];
`endif

  int n_vec = 0, n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h, want %h", name, cyc, act, req);
    end
  endtask

  // Compare process: every cycle, every output against the model's expectation
  logic [31:0] held = '0;
  int          tmo_cnt = 0;
  logic [31:0] last_eaddr = '0;
  initial begin
    forever begin
      @(negedge clk);
      if (cyc >= 1 && cyc < MAXC) begin
        if (exp_zero[cyc]) begin
          held       = '0;
          tmo_cnt    = 0;
          last_eaddr = '0;
          chk("tgt_addr_rst", tgt_addr_o, 32'h0);
          chk("tgt_wdata_rst", tgt_wr_data_o, 32'h0);
        end
        if (exp_ack[cyc] || exp_err[cyc]) held = exp_data[cyc];
        chk("ack", 32'(rbus_ack_o), 32'(exp_ack[cyc]));
        chk("err_ack", 32'(rbus_err_ack_o), 32'(exp_err[cyc]));
        chk("drop", 32'(rbus_drop_o), 32'(exp_drop[cyc]));
        chk("rd_data", rbus_rd_data_o, held);
        chk("tgt_wr_strb", 32'(tgt_wr_strb_o), 32'(exp_twr[cyc]));
        chk("tgt_rd_strb", 32'(tgt_rd_strb_o), 32'(exp_trd[cyc]));
        if ((exp_twr[cyc] | exp_trd[cyc]) != 4'b0) begin
          chk("tgt_addr", tgt_addr_o, exp_taddr[cyc]);
          chk("tgt_wdata", tgt_wr_data_o, exp_twd[cyc]);
        end
`ifdef NX_RBUS_DECODE_STATUS_EN
        if (exp_tmo[cyc] && tmo_cnt < 65535) tmo_cnt = tmo_cnt + 1;
        if (exp_err[cyc]) last_eaddr = exp_eaddr[cyc];
        chk("timeout_cnt", 32'(timeout_cnt_o), 32'(tmo_cnt));
        chk("last_err_addr", last_err_addr_o, last_eaddr);
`endif
      end
    end
  end

  // Literal expectations for directed transactions, offsets relative to the strobe cycle
  logic        pin_s = 1'b0;
  logic [3:0]  pin_twr = '0, pin_trd = '0;
  int          pin_c = -1, pin_drop = -1;
  logic        pin_ack = 1'b0, pin_err = 1'b0;
  logic [31:0] pin_data = '0;

  task automatic drive_tgt(input int quiet_sel);
    logic [3:0] a, e;
    a = 4'($urandom);
    e = 4'($urandom);
    if ($urandom_range(0, 2) != 0) a = '0;
    if ($urandom_range(0, 2) != 0) e = '0;
    if (quiet_sel >= 0) begin
      a[quiet_sel] = 1'b0;
      e[quiet_sel] = 1'b0;
    end
    tgt_ack_i     = a;
    tgt_err_ack_i = e;
    for (int t = 0; t < 4; t++) tgt_rd_data_i[t*32 +: 32] = $urandom;
  endtask

  task automatic idle_cycle();
    rbus_wr_strb_i = 1'b0;
    rbus_rd_strb_i = 1'b0;
    drive_tgt(-1);
    @(negedge clk);
  endtask

  // kind: 0 ack, 1 err_ack, 2 both; d: response delay after the target strobe (>= T means none)
  task automatic run_txn(input logic [31:0] a, input logic [31:0] wd, input logic rd, input logic wr,
                         input int d, input int kind, input logic [31:0] rdat,
                         input int stray, input int late);
    int c, comp, resp, last, stray_c, late_c, quiet_end;
    logic [1:0] sel;
    logic dec;
    c    = cyc;
    sel  = a[13:12];
    dec  = (rd && wr) || !MASK[sel];
    resp = -1;
    if (dec) begin
      comp = c + 1;
      exp_err[comp]  = 1'b1;
      exp_data[comp] = TDATA;
    end else begin
      if (rd) exp_trd[c+1] = 4'b1 << sel;
      else    exp_twr[c+1] = 4'b1 << sel;
      exp_taddr[c+1] = a;
      exp_twd[c+1]   = wd;
      if (d < T) begin
        resp = c + 1 + d;
        comp = resp + 1;
        if (kind != 0) begin
          exp_err[comp]  = 1'b1;
          exp_data[comp] = rdat;
        end else begin
          exp_ack[comp]  = 1'b1;
          exp_data[comp] = rd ? rdat : 32'h0;
        end
      end else begin
        comp = c + T + 1;
        exp_err[comp]  = 1'b1;
        exp_data[comp] = TDATA;
`ifdef NX_RBUS_DECODE_STATUS_EN
        exp_tmo[comp]  = 1'b1;
`endif
      end
    end
`ifdef NX_RBUS_DECODE_STATUS_EN
    if (exp_err[comp]) exp_eaddr[comp] = a;
`endif
    quiet_end = (resp >= 0) ? resp : c + T;
    stray_c   = (stray > 0) ? c + ((stray <= comp - c) ? stray : comp - c) : -1;
    late_c    = (late > 0 && c + late >= comp) ? c + late : -1;
    last      = (late_c > comp) ? late_c : comp;

    rbus_addr_i    = a;
    rbus_wr_data_i = wd;
    rbus_rd_strb_i = rd;
    rbus_wr_strb_i = wr;
    drive_tgt(-1);
    for (int n = c + 1; n <= last; n++) begin
      @(negedge clk);
      if (pin_s && n == c + 1) begin
        chk("pin_tgt_wr_strb", 32'(tgt_wr_strb_o), 32'(pin_twr));
        chk("pin_tgt_rd_strb", 32'(tgt_rd_strb_o), 32'(pin_trd));
      end
      if (n == c + pin_c) begin
        chk("pin_ack", 32'(rbus_ack_o), 32'(pin_ack));
        chk("pin_err_ack", 32'(rbus_err_ack_o), 32'(pin_err));
        chk("pin_rd_data", rbus_rd_data_o, pin_data);
      end
      if (n == c + pin_drop) chk("pin_drop", 32'(rbus_drop_o), 32'h1);
      if (n == stray_c) begin
        rbus_addr_i    = $urandom;
        rbus_wr_data_i = $urandom;
        {rbus_wr_strb_i, rbus_rd_strb_i} = 2'($urandom_range(1, 3));
        exp_drop[n+1] = 1'b1;
      end else begin
        rbus_wr_strb_i = 1'b0;
        rbus_rd_strb_i = 1'b0;
      end
      drive_tgt((!dec && n <= quiet_end) ? int'(sel) : -1);
      if (n == resp) begin
        tgt_ack_i[sel]     = (kind != 1);
        tgt_err_ack_i[sel] = (kind != 0);
        tgt_rd_data_i[sel*32 +: 32] = rdat;
      end
      if (n == late_c) tgt_ack_i[sel] = 1'b1;
    end
    @(negedge clk);
    pin_s    = 1'b0;
    pin_c    = -1;
    pin_drop = -1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int c, d, kind, stray, late, p;
    logic rd, wr;
    logic [31:0] a;
    for (int i = 0; i < MAXC; i++) begin
      exp_ack[i] = 1'b0; exp_err[i] = 1'b0; exp_drop[i] = 1'b0; exp_zero[i] = 1'b0;
      exp_data[i] = '0; exp_twr[i] = '0; exp_trd[i] = '0; exp_taddr[i] = '0; exp_twd[i] = '0;
`ifdef NX_RBUS_DECODE_STATUS_EN
      exp_tmo[i] = 1'b0; exp_eaddr[i] = '0;
`endif
    end
    for (int i = 1; i <= 3; i++) exp_zero[i] = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle_cycle();

    // Read to target 2, acked two cycles after its strobe
    pin_s = 1'b1; pin_twr = 4'b0000; pin_trd = 4'b0100;
    pin_c = 4; pin_ack = 1'b1; pin_err = 1'b0; pin_data = 32'h1234_5678;
    run_txn(32'h0000_2010, $urandom, 1'b1, 1'b0, 2, 0, 32'h1234_5678, 0, 0);

    // Write to target 1, acked in the strobe cycle
    pin_s = 1'b1; pin_twr = 4'b0010; pin_trd = 4'b0000;
    pin_c = 2; pin_ack = 1'b1; pin_err = 1'b0; pin_data = 32'h0;
    run_txn(32'h0000_1004, 32'hA5A5_A5A5, 1'b0, 1'b1, 0, 0, $urandom, 0, 0);

    // Timeout on target 0 with a late ack afterwards
    pin_s = 1'b1; pin_twr = 4'b0000; pin_trd = 4'b0001;
    pin_c = 17; pin_ack = 1'b0; pin_err = 1'b1; pin_data = TDATA;
    run_txn(32'h0000_0040, $urandom, 1'b1, 1'b0, 99, 0, 32'h0, 0, 20);
`ifdef NX_RBUS_DECODE_STATUS_EN
    chk("lit_timeout_cnt", 32'(timeout_cnt_o), 32'h1);
    chk("lit_last_err_addr", last_err_addr_o, 32'h0000_0040);
`endif

    // Decode errors: unpopulated target 3, then both strobes together
    pin_s = 1'b1; pin_twr = 4'b0000; pin_trd = 4'b0000;
    pin_c = 1; pin_ack = 1'b0; pin_err = 1'b1; pin_data = TDATA;
    run_txn(32'h0000_3000, $urandom, 1'b0, 1'b1, 0, 0, 32'h0, 0, 0);
    pin_s = 1'b1; pin_twr = 4'b0000; pin_trd = 4'b0000;
    pin_c = 1; pin_ack = 1'b0; pin_err = 1'b1; pin_data = TDATA;
    run_txn(32'h0000_1000, $urandom, 1'b1, 1'b1, 0, 0, 32'h0, 0, 0);

    // ack+err together, with a stray strobe while waiting
    pin_c = 3; pin_ack = 1'b0; pin_err = 1'b1; pin_data = 32'h0BAD_F00D; pin_drop = 3;
    run_txn(32'h0000_0008, $urandom, 1'b1, 1'b0, 1, 2, 32'h0BAD_F00D, 2, 0);

    // Reset in the second WAIT cycle, then a normal read
    c = cyc;
    a = 32'h0000_1020;
    rbus_addr_i = a; rbus_wr_data_i = $urandom; rbus_rd_strb_i = 1'b1; rbus_wr_strb_i = 1'b0;
    exp_trd[c+1] = 4'b0010; exp_taddr[c+1] = a; exp_twd[c+1] = rbus_wr_data_i;
    drive_tgt(-1);
    @(negedge clk);
    rbus_rd_strb_i = 1'b0;
    drive_tgt(1);
    @(negedge clk);
    rst = 1'b1;
    exp_zero[c+3] = 1'b1;
    drive_tgt(1);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_ack", 32'(rbus_ack_o), 32'h0);
    chk("rst_err_ack", 32'(rbus_err_ack_o), 32'h0);
    chk("rst_rd_data", rbus_rd_data_o, 32'h0);
    chk("rst_tgt_addr", tgt_addr_o, 32'h0);
    drive_tgt(-1);
    @(negedge clk);
    pin_s = 1'b1; pin_twr = 4'b0000; pin_trd = 4'b0010;
    pin_c = 3; pin_ack = 1'b1; pin_err = 1'b0; pin_data = 32'hCAFE_0001;
    run_txn(32'h0000_1030, $urandom, 1'b1, 1'b0, 1, 0, 32'hCAFE_0001, 0, 0);

    for (int i = 0; i < 250; i++) begin
      repeat ($urandom_range(0, 2)) idle_cycle();
      a = $urandom;
      p = $urandom_range(0, 9);
      rd = (p == 0) || (p < 5);
      wr = (p == 0) || (p >= 5);
      p = $urandom_range(0, 19);
      d = (p < 14) ? $urandom_range(0, 5) : (p < 17) ? $urandom_range(6, 16) : 99;
      p = $urandom_range(0, 7);
      kind = (p < 5) ? 0 : (p < 7) ? 1 : 2;
      stray = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 20) : 0;
      late = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 22) : 0;
      run_txn(a, $urandom, rd, wr, d, kind, $urandom, stray, late);
    end

    repeat (3) idle_cycle();
    @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
